display_timing_gen: RTL

DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

---
 rtl/disp_timing_pkg.sv | 21 ++
 rtl/pixel_clk_div.sv | 30 +++
 rtl/display_timing_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/disp_timing_pkg.sv
// Shared timing constants and line-FSM encoding for the display timing generator.
// Consumers use these defaults when no parameter override is supplied.
package disp_timing_pkg;

    localparam int CNT_W       = 10;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int H_SYNC_W    = 96;
    localparam int V_SYNC_W    = 2;
    localparam int H_ACT_START = 144;
    localparam int H_ACT_END   = 783;
    localparam int V_ACT_START = 35;
    localparam int V_ACT_END   = 514;

    typedef enum logic {
        BLANK_LINE  = 1'b0,
        ACTIVE_LINE = 1'b1
    } line_state_t;

endpackage

// File: rtl/pixel_clk_div.sv
// Pixel-rate strobe source. With DISP_TIMING_PIXEL_DIV_EN defined a 2-bit divider
// yields one strobe every 4 clks; otherwise every clk is a pixel clock.
module pixel_clk_div (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

`ifdef DISP_TIMING_PIXEL_DIV_EN
    logic [1:0] div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    // Strobe on the last divider phase so the first advance lands on the 4th edge.
    assign pix_en = (div == 2'd3);
`else
    logic unused_clk;
    assign unused_clk = clk;

    // Held low only while reset is asserted; constant high otherwise.
    assign pix_en = rst;
`endif

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing generator: pixel/line counters, sync and visible-window decode,
// frame tick. Build with DISP_TIMING_PIXEL_DIV_EN for a divided (clk/4) pixel rate.
module display_timing_gen #(
    parameter int H_TOTAL     = disp_timing_pkg::H_TOTAL,
    parameter int V_TOTAL     = disp_timing_pkg::V_TOTAL,
    parameter int H_SYNC_W    = disp_timing_pkg::H_SYNC_W,
    parameter int V_SYNC_W    = disp_timing_pkg::V_SYNC_W,
    parameter int H_ACT_START = disp_timing_pkg::H_ACT_START,
    parameter int H_ACT_END   = disp_timing_pkg::H_ACT_END,
    parameter int V_ACT_START = disp_timing_pkg::V_ACT_START,
    parameter int V_ACT_END   = disp_timing_pkg::V_ACT_END
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       pix_en,
    output logic       frame_tick
);

    import disp_timing_pkg::*;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_W     = CNT_W'(H_SYNC_W);
    localparam logic [CNT_W-1:0] VS_W     = CNT_W'(V_SYNC_W);
    localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_ACT_START);
    localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_ACT_END);
    localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_ACT_START);
    localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_ACT_END);
    // First blank line after the window, folded back to 0 if the window ends on the last line.
    localparam logic [CNT_W-1:0] VB_START = CNT_W'((V_ACT_END + 1) % V_TOTAL);

    line_state_t      state;
    line_state_t      state_next;
    logic             h_wrap;
    logic [CNT_W-1:0] v_next;

    pixel_clk_div u_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    assign h_wrap = pix_en && (hCount == H_LAST);
    assign v_next = (vCount == V_LAST) ? '0 : vCount + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hCount <= '0;
            vCount <= '0;
        end else if (pix_en) begin
            if (hCount == H_LAST) begin
                hCount <= '0;
                vCount <= v_next;
            end else begin
                hCount <= hCount + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= h_wrap && (vCount == V_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BLANK_LINE;
        end else begin
            state <= state_next;
        end
    end

    // Vertical region changes only at a line wrap; entering the window wins a tie.
    always_comb begin
        state_next = state;
        if (h_wrap) begin
            if (v_next == VA_START) begin
                state_next = ACTIVE_LINE;
            end else if (v_next == VB_START) begin
                state_next = BLANK_LINE;
            end
        end
    end

    always_comb begin
        hSync  = !(hCount < HS_W);
        vSync  = !(vCount < VS_W);
        bright = 1'b0;
        if ((state == ACTIVE_LINE) &&
            (hCount >= HA_START) && (hCount <= HA_END) &&
            (vCount >= VA_START) && (vCount <= VA_END)) begin
            bright = 1'b1;
        end
    end

endmodule
